// File: rtl/mc_ctrl.sv
// Multi-cycle RV32 control sequencer: shared memory port, memory timeout trap, illegal-opcode trap.
// Optional MC_INSTRET_EN builds the retired-instruction counter; otherwise instret reads 0.
module mc_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_src,
    output logic [3:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [WIDTH-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
        S_MEMWB = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
        S_ALUWB = 4'd8,  S_BRANCH = 4'd9,  S_JAL = 4'd10,  S_JALR = 4'd11,
        S_JALRL = 4'd12, S_TRAP = 4'd15
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic [7:0] wait_q, wait_d;
    logic       retire;
    logic       timeout;
    logic       br_ok;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr;
    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign unused_instr = ^{instr[31:15], instr[11:7]};

    assign timeout = (wait_q == TIMEOUT_C) && !mem_ready;
    assign br_ok   = (funct3 == 3'b000) || (funct3 == 3'b001);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cause_q <= 2'b00;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) begin state_d = S_TRAP; cause_d = 2'b10; end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I, OP_LUI:      state_d = S_EXECI;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default:           begin state_d = S_TRAP; cause_d = 2'b01; end
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (mem_ready)    state_d = S_MEMWB;
                else if (timeout) begin state_d = S_TRAP; cause_d = 2'b10; end
            end
            S_MEMWRITE: begin
                if (mem_ready)    begin state_d = S_FETCH; retire = 1'b1; end
                else if (timeout) begin state_d = S_TRAP; cause_d = 2'b10; end
            end
            S_MEMWB, S_ALUWB: begin state_d = S_FETCH; retire = 1'b1; end
            S_EXECR, S_EXECI, S_JAL, S_JALRL: state_d = S_ALUWB;
            S_JALR:    state_d = S_JALRL;
            S_BRANCH: begin
                if (br_ok) begin state_d = S_FETCH; retire = 1'b1; end
                else       begin state_d = S_TRAP; cause_d = 2'b01; end
            end
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_TRAP;
        endcase
    end

    // The wait counter only runs while a memory access is stalled in place.
    always_comb begin
        wait_d = 8'd0;
        if ((state_d == state_q) && !mem_ready &&
            (state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE))
            wait_d = wait_q + 8'd1;
    end

    // Strobes are held low while reset is asserted so no write leaks out of reset.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
                S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
                S_MEMREAD:  begin mem_req = 1'b1; adr_src = 1'b1; end
                S_MEMWB:    begin reg_write = 1'b1; result_src = 2'b01; end
                S_MEMWRITE: begin mem_req = 1'b1; mem_we = 1'b1; adr_src = 1'b1; end
                S_EXECR:    begin alu_src_a = 2'b10; alu_op = 2'b10; end
                S_EXECI: begin
                    alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = (opcode == OP_LUI) ? 2'b00 : 2'b10;
                end
                S_ALUWB:    reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    pc_write  = Zero ^ funct3[0];
                end
                S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
                S_JALR: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                end
                S_JALRL:    begin alu_src_a = 2'b01; alu_src_b = 2'b10; end
                default:    ;
            endcase
        end
    end

    // Immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
    always_comb begin
        case (opcode)
            OP_STORE:        imm_src = 3'b001;
            OP_BR:           imm_src = 3'b010;
            OP_JAL:          imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:         imm_src = 3'b000;
        endcase
    end

    assign state      = state_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;

`ifdef MC_INSTRET_EN
    logic [WIDTH-1:0] instret_q;
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)      instret_q <= '0;
        else if (retire) instret_q <= instret_q + 1'b1;
    end
    assign instret = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign instret       = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl (WIDTH=4, MEM_TIMEOUT=4); instret expectations follow MC_INSTRET_EN.
module tb_mc_ctrl;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        Zero;
    logic        mem_ready;
    logic        mem_req, mem_we, adr_src, pc_write, ir_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src, trap_cause;
    logic [2:0]  imm_src;
    logic [3:0]  state;
    logic        trap;
    logic [3:0]  instret;

`ifdef MC_INSTRET_EN
    localparam bit INSTRET_EN = 1'b1;
`else
    localparam bit INSTRET_EN = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    mc_ctrl #(.WIDTH(4), .MEM_TIMEOUT(4)) dut (
        .CLK(CLK), .rst_n(rst_n), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .pc_write(pc_write),
        .ir_write(ir_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .imm_src(imm_src), .state(state), .trap(trap), .trap_cause(trap_cause),
        .instret(instret)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk_ret(input string tag);
        chk(tag, 32'(instret), INSTRET_EN ? 32'(exp_ret % 16) : 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_ret = 0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; instr = 32'h0; Zero = 1'b0; mem_ready = 1'b1;
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_ir_write", 32'(ir_write), 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        rst_n = 1'b1;
        #1;

        // addi x1,x0,5 with zero-wait memory: 0,1,7,8,0
        instr = 32'h00500093;
        chk("addi_f_mem_req", 32'(mem_req), 32'd1);
        chk("addi_f_ir_write", 32'(ir_write), 32'd1);
        chk("addi_f_pc_write", 32'(pc_write), 32'd1);
        chk("addi_f_srcb", 32'(alu_src_b), 32'd2);
        chk("addi_f_res", 32'(result_src), 32'd2);
        chk("addi_f_regw", 32'(reg_write), 32'd0);
        tick();
        chk("addi_d_state", 32'(state), 32'd1);
        chk("addi_d_srca", 32'(alu_src_a), 32'd1);
        chk("addi_d_imm", 32'(imm_src), 32'd0);
        chk("addi_d_regw", 32'(reg_write), 32'd0);
        tick();
        chk("addi_e_state", 32'(state), 32'd7);
        chk("addi_e_srca", 32'(alu_src_a), 32'd2);
        chk("addi_e_srcb", 32'(alu_src_b), 32'd1);
        chk("addi_e_op", 32'(alu_op), 32'd2);
        chk("addi_e_regw", 32'(reg_write), 32'd0);
        tick();
        chk("addi_wb_state", 32'(state), 32'd8);
        chk("addi_wb_regw", 32'(reg_write), 32'd1);
        chk("addi_wb_res", 32'(result_src), 32'd0);
        tick();
        exp_ret = 1;
        chk("addi_end_state", 32'(state), 32'd0);
        chk_ret("addi_instret");

        // lw with 3 wait cycles in FETCH and in MEMREAD: 11 cycles
        instr = 32'h0000A103;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_fwait_state", 32'(state), 32'd0);
            chk("lw_fwait_req", 32'(mem_req), 32'd1);
            chk("lw_fwait_adr", 32'(adr_src), 32'd0);
            chk("lw_fwait_irw", 32'(ir_write), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_f_state", 32'(state), 32'd0);
        chk("lw_f_irw", 32'(ir_write), 32'd1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("lw_d_state", 32'(state), 32'd1);
        tick();
        chk("lw_ma_state", 32'(state), 32'd2);
        chk("lw_ma_srca", 32'(alu_src_a), 32'd2);
        chk("lw_ma_srcb", 32'(alu_src_b), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_rwait_state", 32'(state), 32'd3);
            chk("lw_rwait_req", 32'(mem_req), 32'd1);
            chk("lw_rwait_adr", 32'(adr_src), 32'd1);
            chk("lw_rwait_we", 32'(mem_we), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_r_state", 32'(state), 32'd3);
        tick();
        chk("lw_wb_state", 32'(state), 32'd4);
        chk("lw_wb_res", 32'(result_src), 32'd1);
        chk("lw_wb_regw", 32'(reg_write), 32'd1);
        tick();
        exp_ret = 2;
        chk("lw_end_state", 32'(state), 32'd0);
        chk_ret("lw_instret");

        // beq taken, then bne not taken, both with Zero=1
        instr = 32'h00000463; Zero = 1'b1;
        tick();
        chk("beq_d_imm", 32'(imm_src), 32'd2);
        tick();
        chk("beq_state", 32'(state), 32'd9);
        chk("beq_pcw", 32'(pc_write), 32'd1);
        chk("beq_op", 32'(alu_op), 32'd1);
        tick();
        exp_ret = 3;
        chk("beq_end_state", 32'(state), 32'd0);
        chk_ret("beq_instret");
        instr = 32'h00001463;
        tick();
        tick();
        chk("bne_state", 32'(state), 32'd9);
        chk("bne_pcw", 32'(pc_write), 32'd0);
        tick();
        exp_ret = 4;
        chk("bne_end_state", 32'(state), 32'd0);
        chk_ret("bne_instret");
        Zero = 1'b0;

        // Bus timeout: 4 waits allowed, trap after the 5th stalled FETCH cycle
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("to_fetch_state", 32'(state), 32'd0);
            if (i < 4) tick();
        end
        tick();
        chk("to_state", 32'(state), 32'd15);
        chk("to_trap", 32'(trap), 32'd1);
        chk("to_cause", 32'(trap_cause), 32'd2);
        chk("to_mem_req", 32'(mem_req), 32'd0);
        do_reset();

        // Ready arriving on the 5th cycle completes the fetch (AUIPC follows)
        instr = 32'h00000017;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        mem_ready = 1'b1;
        #1;
        chk("to5_state", 32'(state), 32'd0);
        chk("to5_irw", 32'(ir_write), 32'd1);
        tick();
        chk("to5_d_state", 32'(state), 32'd1);
        chk("to5_trap", 32'(trap), 32'd0);
        tick();
        chk("auipc_state", 32'(state), 32'd8);
        tick();
        exp_ret = 1;
        chk("auipc_end_state", 32'(state), 32'd0);
        chk_ret("auipc_instret");

        // Illegal opcode traps; later mem_ready pulses do nothing
        instr = 32'h0000007F;
        tick();
        tick();
        chk("ill_state", 32'(state), 32'd15);
        chk("ill_trap", 32'(trap), 32'd1);
        chk("ill_cause", 32'(trap_cause), 32'd1);
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i != 1);
            #1;
            chk("ill_hold_state", 32'(state), 32'd15);
            chk("ill_hold_pcw", 32'(pc_write), 32'd0);
            chk("ill_hold_req", 32'(mem_req), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        do_reset();

        // 17 AUIPC retirements wrap a 4-bit instret to 1
        instr = 32'h00000017;
        for (int n = 1; n <= 17; n++) begin
            tick();
            tick();
            tick();
            exp_ret = n;
            if (n == 16) chk_ret("wrap16_instret");
        end
        chk("wrap_state", 32'(state), 32'd0);
        chk_ret("wrap17_instret");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
